// File: rtl/precision_tran_down_pipe.sv
// Two-stage streaming float narrowing converter (default FP16 E5M10 -> FP8 E4M3).
// S1 classifies and rebiases; S2 rounds to nearest even, packs and raises per-sample flags.
module precision_tran_down_pipe #(
    parameter int unsigned EXP_WIDTH_IN   = 5,
    parameter int unsigned FRAC_WIDTH_IN  = 10,
    parameter int unsigned EXP_WIDTH_OUT  = 4,
    parameter int unsigned FRAC_WIDTH_OUT = 3
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [EXP_WIDTH_IN+FRAC_WIDTH_IN:0]     float_num_in,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [EXP_WIDTH_OUT+FRAC_WIDTH_OUT:0]   float_num_out,
    output logic                                    invalid,
    output logic                                    overflow,
    output logic                                    underflow,
    input  logic                                    clr_flags,
    output logic [2:0]                              sticky_flags
);

    localparam int unsigned EI   = EXP_WIDTH_IN;
    localparam int unsigned FI   = FRAC_WIDTH_IN;
    localparam int unsigned EO   = EXP_WIDTH_OUT;
    localparam int unsigned FO   = FRAC_WIDTH_OUT;
    localparam int unsigned EW   = EI + 2;
    localparam int unsigned DROP = FI - FO;
    localparam int unsigned OW   = 1 + EO + FO;

    localparam int unsigned BIAS_IN  = (1 << (EI - 1)) - 1;
    localparam int unsigned BIAS_OUT = (1 << (EO - 1)) - 1;

    localparam logic [EW-1:0]   BIAS_DIFF   = EW'(BIAS_IN - BIAS_OUT);
    localparam logic [EW-1:0]   EXP_MAX     = EW'((1 << EO) - 1);
    localparam logic [DROP-1:0] STICKY_MASK = DROP'((1 << (DROP - 1)) - 1);
    localparam logic [FO-1:0]   NAN_FRAC    = FO'(1 << (FO - 1));

    typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} cls_e;

    logic          in_sign;
    logic [EI-1:0] in_exp;
    logic [FI-1:0] in_frac;

    assign in_sign = float_num_in[EI+FI];
    assign in_exp  = float_num_in[EI+FI-1:FI];
    assign in_frac = float_num_in[FI-1:0];

    // Handshake
    logic s1_valid_q;
    logic s2_valid_q;
    logic s2_adv;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    // Stage 1: classify, rebias, split fraction into kept/guard/sticky
    cls_e          s1_cls_d;
    logic [EW-1:0] s1_e_d;

    always_comb begin
        s1_cls_d = ClsNorm;
        if (in_exp == '1) begin
            s1_cls_d = (in_frac != '0) ? ClsNan : ClsInf;
        end else if (in_exp == '0) begin
            s1_cls_d = ClsZero;
        end
    end

    // Two's-complement exponent; two extra bits cover the full signed range.
    assign s1_e_d = {2'b00, in_exp} - BIAS_DIFF;

    cls_e          s1_cls_q;
    logic          s1_sign_q;
    logic [EW-1:0] s1_e_q;
    logic [FO-1:0] s1_frac_q;
    logic          s1_guard_q;
    logic          s1_sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_cls_q    <= ClsZero;
            s1_sign_q   <= 1'b0;
            s1_e_q      <= '0;
            s1_frac_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_cls_q    <= s1_cls_d;
                s1_sign_q   <= in_sign;
                s1_e_q      <= s1_e_d;
                s1_frac_q   <= in_frac[FI-1:DROP];
                s1_guard_q  <= in_frac[DROP-1];
                s1_sticky_q <= |(in_frac[DROP-1:0] & STICKY_MASK);
            end
        end
    end

    // Stage 2: round-to-nearest-even, overflow/underflow decisions, packing
    logic          round_up;
    logic [FO:0]   frac_sum;
    logic          carry;
    logic [EW-1:0] e_rnd;
    logic          e_low;

    assign round_up = s1_guard_q & (s1_sticky_q | s1_frac_q[0]);
    assign frac_sum = {1'b0, s1_frac_q} + {{FO{1'b0}}, round_up};
    assign carry    = frac_sum[FO];
    assign e_rnd    = s1_e_q + {{(EW-1){1'b0}}, carry};
    // Underflow is judged on the pre-rounding exponent.
    assign e_low    = s1_e_q[EW-1] || (s1_e_q == '0);

    logic [OW-1:0] out_d;
    logic          inv_d;
    logic          ovf_d;
    logic          unf_d;

    always_comb begin
        out_d = {s1_sign_q, {(EO+FO){1'b0}}};
        inv_d = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        unique case (s1_cls_q)
            ClsNan: begin
                out_d = {s1_sign_q, {EO{1'b1}}, NAN_FRAC};
                inv_d = 1'b1;
            end
            ClsInf: begin
                out_d = {s1_sign_q, {EO{1'b1}}, {FO{1'b0}}};
            end
            ClsZero: begin
                out_d = {s1_sign_q, {(EO+FO){1'b0}}};
            end
            ClsNorm: begin
                if (e_low) begin
                    unf_d = 1'b1;
                end else if (!e_rnd[EW-1] && (e_rnd >= EXP_MAX)) begin
                    out_d = {s1_sign_q, {EO{1'b1}}, {FO{1'b0}}};
                    ovf_d = 1'b1;
                end else begin
                    out_d = {s1_sign_q, e_rnd[EO-1:0], carry ? {FO{1'b0}} : frac_sum[FO-1:0]};
                end
            end
        endcase
    end

    logic [OW-1:0] out_q;
    logic          inv_q;
    logic          ovf_q;
    logic          unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            inv_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_q <= out_d;
                inv_q <= inv_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end
    end

    assign out_valid     = s2_valid_q;
    assign float_num_out = out_q;
    assign invalid       = inv_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

    // Sticky flags: a clear never swallows a flag transferred in the same cycle.
    logic       xfer;
    logic [2:0] sticky_d;
    logic [2:0] sticky_q;

    assign xfer     = s2_valid_q && out_ready;
    assign sticky_d = (clr_flags ? 3'b000 : sticky_q) | (xfer ? {inv_q, ovf_q, unf_q} : 3'b000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 3'b000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_precision_tran_down_pipe.sv
// Bench for precision_tran_down_pipe: directed vector table, stall/reset sequences and
// randomized traffic scored against an arithmetic reference model.
module tb_precision_tran_down_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] float_num_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  float_num_out;
    logic        invalid;
    logic        overflow;
    logic        underflow;
    logic        clr_flags;
    logic [2:0]  sticky_flags;

    int total = 0;
    int bad   = 0;

    // Expected outputs in order: {float_num_out, invalid, overflow, underflow}
    logic [10:0] exp_q[$];

    typedef struct {
        logic [15:0] din;
        logic [7:0]  dout;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs[18];

    always #5 clk = ~clk;

    precision_tran_down_pipe #(
        .EXP_WIDTH_IN   (5),
        .FRAC_WIDTH_IN  (10),
        .EXP_WIDTH_OUT  (4),
        .FRAC_WIDTH_OUT (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .float_num_in  (float_num_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .float_num_out (float_num_out),
        .invalid       (invalid),
        .overflow      (overflow),
        .underflow     (underflow),
        .clr_flags     (clr_flags),
        .sticky_flags  (sticky_flags)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: value-level rounding of the 11-bit significand to 4 bits.
    function automatic logic [10:0] model(input logic [15:0] x);
        int ex, fr, eo, sig, q, rem;
        ex = int'(x[14:10]);
        fr = int'(x[9:0]);
        if (ex == 31) return (fr != 0) ? {x[15], 7'h7C, 3'b100} : {x[15], 7'h78, 3'b000};
        if (ex == 0) return {x[15], 7'h00, 3'b000};
        eo = ex - 15 + 7;
        if (eo <= 0) return {x[15], 7'h00, 3'b001};
        sig = 1024 + fr;
        q   = sig / 128;
        rem = sig % 128;
        if (rem > 64 || (rem == 64 && (q % 2) == 1)) q++;
        if (q == 16) begin
            q = 8;
            eo++;
        end
        if (eo >= 15) return {x[15], 7'h78, 3'b010};
        return {x[15], 4'(eo), 3'(q - 8), 3'b000};
    endfunction

    // Output scoreboard: every visible output must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %0h want no output", float_num_out);
            end else begin
                check("out", {21'b0, float_num_out, invalid, overflow, underflow},
                      {21'b0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Single sample into an empty pipe; out_valid must rise two cycles after the accept.
    task automatic apply_vec(input logic [15:0] din, input logic [7:0] dout,
                             input logic [2:0] flags);
        in_valid     = 1'b1;
        float_num_in = din;
        @(negedge clk);
        check("vec_in_ready", in_ready, 1);
        if (in_ready) exp_q.push_back({dout, flags});
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("vec_lat1", out_valid, 0);
        tick();
        @(negedge clk);
        check("vec_lat2", out_valid, 1);
        tick();
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clear", sticky_flags, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sent;

        vecs[0]  = '{16'h3C00, 8'h38, 3'b000};
        vecs[1]  = '{16'h3CC0, 8'h3A, 3'b000};
        vecs[2]  = '{16'h3C40, 8'h38, 3'b000};
        vecs[3]  = '{16'h5B80, 8'h77, 3'b000};
        vecs[4]  = '{16'h5BC0, 8'h78, 3'b010};
        vecs[5]  = '{16'hFC00, 8'hF8, 3'b000};
        vecs[6]  = '{16'h7E00, 8'h7C, 3'b100};
        vecs[7]  = '{16'hA000, 8'h80, 3'b001};
        vecs[8]  = '{16'h0001, 8'h00, 3'b000};
        vecs[9]  = '{16'h8000, 8'h80, 3'b000};
        vecs[10] = '{16'h7C00, 8'h78, 3'b000};
        vecs[11] = '{16'h3C80, 8'h39, 3'b000};
        vecs[12] = '{16'h2400, 8'h08, 3'b000};
        vecs[13] = '{16'h3C41, 8'h39, 3'b000};
        vecs[14] = '{16'hFE01, 8'hFC, 3'b100};
        vecs[15] = '{16'h2000, 8'h00, 3'b001};
        vecs[16] = '{16'h5B7F, 8'h77, 3'b000};
        vecs[17] = '{16'h5C00, 8'h78, 3'b010};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        float_num_in = '0;
        out_ready    = 1'b1;
        clr_flags    = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", {float_num_out, invalid, overflow, underflow}, 0);
        check("rst_sticky", sticky_flags, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        for (int i = 0; i < 18; i++) begin
            apply_vec(vecs[i].din, vecs[i].dout, vecs[i].flags);
            if (i == 5) begin
                check("sticky_ovf", sticky_flags, 3'b010);
                clear_flags();
            end
            if (i == 8) check("sticky_inv_unf", sticky_flags, 3'b101);
        end

        // Back-pressure: out_ready low for 3 cycles with 8 samples streaming
        sent     = 0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 60 && (sent < 8 || exp_q.size() != 0); cyc++) begin
            if (!in_valid && sent < 8) begin
                in_valid     = 1'b1;
                float_num_in = 16'($urandom);
            end
            out_ready = !(cyc >= 4 && cyc <= 6);
            @(negedge clk);
            if (cyc >= 4 && cyc <= 6) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
            end
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(model(float_num_in));
                sent++;
            end
            tick();
            if (acc) in_valid = 1'b0;
        end
        check("stall_sent", sent, 8);
        check("stall_drain", exp_q.size(), 0);

        // Randomized traffic against the reference model
        sent = 0;
        for (int cyc = 0; cyc < 5000 && (sent < 300 || exp_q.size() != 0); cyc++) begin
            if (!in_valid && sent < 300 && $urandom_range(0, 3) != 0) begin
                in_valid     = 1'b1;
                float_num_in = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(model(float_num_in));
                sent++;
            end
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("random_sent", sent, 300);
        check("random_drain", exp_q.size(), 0);

        // Reset with two samples in flight
        apply_vec(16'h7E00, 8'h7C, 3'b100);
        out_ready    = 1'b0;
        in_valid     = 1'b1;
        float_num_in = 16'h3C00;
        @(negedge clk);
        check("inflight_acc0", in_ready, 1);
        exp_q.push_back({8'h38, 3'b000});
        tick();
        float_num_in = 16'h3CC0;
        @(negedge clk);
        check("inflight_acc1", in_ready, 1);
        exp_q.push_back({8'h3A, 3'b000});
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", float_num_out, 0);
        check("midrst_sticky", sticky_flags, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_quiet", out_valid, 0);
        end
        tick();

        // Clear coincident with an overflow transfer
        apply_vec(16'h7E00, 8'h7C, 3'b100);
        apply_vec(16'hA000, 8'h80, 3'b001);
        check("pre_clr_sticky", sticky_flags, 3'b101);
        out_ready    = 1'b0;
        in_valid     = 1'b1;
        float_num_in = 16'h5BC0;
        @(negedge clk);
        check("clr_acc", in_ready, 1);
        exp_q.push_back({8'h78, 3'b010});
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        clr_flags = 1'b1;
        @(negedge clk);
        check("clr_out_valid", out_valid, 1);
        tick();
        clr_flags = 1'b0;
        check("clr_coincident_sticky", sticky_flags, 3'b010);
        check("final_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
